// File: rtl/uart_alu_frame_ctrl.sv
// rtl/uart_alu_frame_ctrl.sv - UART-to-ALU frame controller: opcode/A/B byte collection,
// result byte return, inter-byte timeout abort.
module uart_alu_frame_ctrl #(
  parameter int LEN_DATA       = 8,
  parameter int LEN_OP         = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_done_tick,
  input  logic [7:0]          rx_data_in,
  input  logic                tx_done_tick,
  input  logic [LEN_DATA-1:0] alu_data_in,
  output logic                tx_start,
  output logic [7:0]          data_out,
  output logic [LEN_DATA-1:0] A,
  output logic [LEN_DATA-1:0] B,
  output logic [LEN_OP-1:0]   OPCODE,
  output logic                busy,
  output logic                frame_err
);

  localparam int NB = LEN_DATA / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST    = CW'(NB - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, RX_A, RX_B, EXEC, TX_START, TX_WAIT} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       byte_cnt;
  logic [TW-1:0]       tmo_cnt;
  logic [LEN_DATA-1:0] res_reg;
  logic                last_byte;
  logic                in_rx;
  logic                timed_out;
  logic                unused_rx;

  assign last_byte = (byte_cnt == LAST);
  assign in_rx     = (state == RX_A) || (state == RX_B);
  // An arriving byte beats a timeout that lands in the same cycle.
  assign timed_out = (TIMEOUT_CYCLES != 0) && in_rx && !rx_done_tick && (tmo_cnt == TMO_MAX);
  assign unused_rx = &{1'b0, rx_data_in};

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    frame_err = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:     if (rx_done_tick) state_nxt = RX_A;
      RX_A: begin
        if (timed_out) begin
          frame_err = 1'b1;
          state_nxt = IDLE;
        end else if (rx_done_tick && last_byte) state_nxt = RX_B;
      end
      RX_B: begin
        if (timed_out) begin
          frame_err = 1'b1;
          state_nxt = IDLE;
        end else if (rx_done_tick && last_byte) state_nxt = EXEC;
      end
      EXEC:     state_nxt = TX_START;
      TX_START: begin
        tx_start  = 1'b1;
        state_nxt = TX_WAIT;
      end
      TX_WAIT:  if (tx_done_tick) state_nxt = last_byte ? IDLE : TX_START;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      A        <= '0;
      B        <= '0;
      OPCODE   <= '0;
      res_reg  <= '0;
      byte_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (rx_done_tick) begin
          OPCODE   <= rx_data_in[LEN_OP-1:0];
          byte_cnt <= '0;
        end
        RX_A, RX_B: if (rx_done_tick) begin
          for (int i = 0; i < NB; i++) begin
            if (byte_cnt == CW'(i)) begin
              if (state == RX_A) A[8*i +: 8] <= rx_data_in;
              else               B[8*i +: 8] <= rx_data_in;
            end
          end
          byte_cnt <= last_byte ? '0 : byte_cnt + CW'(1);
        end
        EXEC: begin
          res_reg  <= alu_data_in;
          byte_cnt <= '0;
        end
        TX_WAIT: if (tx_done_tick && !last_byte) byte_cnt <= byte_cnt + CW'(1);
        default: ;
      endcase
      // Saturating so a disabled timeout (TMO_MAX == 0) never counts.
      if (rx_done_tick || !in_rx)  tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NB; i++)
      if (byte_cnt == CW'(i)) data_out = res_reg[8*i +: 8];
  end

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// tb/tb_uart_alu_frame_ctrl.sv - bench for uart_alu_frame_ctrl with 8-bit and 16-bit instances.
module tb_uart_alu_frame_ctrl;
  localparam int T = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, rx_tick, tx_done, sel16;
  logic [7:0] rx_data;
  int         checks = 0, errors = 0;

  logic rx8, txd8, rx16, txd16;
  assign rx8   = rx_tick & ~sel16;
  assign txd8  = tx_done & ~sel16;
  assign rx16  = rx_tick & sel16;
  assign txd16 = tx_done & sel16;

  logic        ts8, busy8, fe8, ts16, busy16, fe16;
  logic [7:0]  d8, d16, a8, b8, alu8;
  logic [5:0]  op8, op16;
  logic [15:0] a16, b16, alu16, alu8_wide;

  function automatic logic [15:0] ref_alu(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      8'h20:   return a + b;
      8'h22:   return a - b;
      8'h24:   return a & b;
      8'h25:   return a | b;
      8'h26:   return a ^ b;
      default: return a;
    endcase
  endfunction

  always_comb begin
    alu8_wide = ref_alu({2'b00, op8}, {8'h00, a8}, {8'h00, b8});
    alu8      = alu8_wide[7:0];
    alu16     = ref_alu({2'b00, op16}, a16, b16);
  end

  uart_alu_frame_ctrl #(.LEN_DATA(8), .LEN_OP(6), .TIMEOUT_CYCLES(T)) u8 (
    .clk(clk), .reset(reset), .rx_done_tick(rx8), .rx_data_in(rx_data), .tx_done_tick(txd8),
    .alu_data_in(alu8), .tx_start(ts8), .data_out(d8), .A(a8), .B(b8), .OPCODE(op8),
    .busy(busy8), .frame_err(fe8));

  uart_alu_frame_ctrl #(.LEN_DATA(16), .LEN_OP(6), .TIMEOUT_CYCLES(T)) u16 (
    .clk(clk), .reset(reset), .rx_done_tick(rx16), .rx_data_in(rx_data), .tx_done_tick(txd16),
    .alu_data_in(alu16), .tx_start(ts16), .data_out(d16), .A(a16), .B(b16), .OPCODE(op16),
    .busy(busy16), .frame_err(fe16));

  logic        cur_ts, cur_busy, cur_fe;
  logic [7:0]  cur_d;
  logic [5:0]  cur_op;
  logic [15:0] cur_a, cur_b;
  always_comb begin
    cur_ts   = sel16 ? ts16   : ts8;
    cur_busy = sel16 ? busy16 : busy8;
    cur_fe   = sel16 ? fe16   : fe8;
    cur_d    = sel16 ? d16    : d8;
    cur_op   = sel16 ? op16   : op8;
    cur_a    = sel16 ? a16    : {8'h00, a8};
    cur_b    = sel16 ? b16    : {8'h00, b8};
  end

  // Protocol monitors: pulse counts and back-to-back tx_start without tx_done.
  int   ts_cnt8 = 0, ts_cnt16 = 0, fe_cnt8 = 0, fe_cnt16 = 0, dbl_viol = 0;
  logic pend8 = 1'b0, pend16 = 1'b0;
  always @(negedge clk) begin
    if (ts8)  ts_cnt8  <= ts_cnt8 + 1;
    if (ts16) ts_cnt16 <= ts_cnt16 + 1;
    if (fe8)  fe_cnt8  <= fe_cnt8 + 1;
    if (fe16) fe_cnt16 <= fe_cnt16 + 1;
    if ((ts8 && pend8) || (ts16 && pend16)) dbl_viol <= dbl_viol + 1;
    pend8  <= !reset ? 1'b0 : ts8  ? 1'b1 : txd8  ? 1'b0 : pend8;
    pend16 <= !reset ? 1'b0 : ts16 ? 1'b1 : txd16 ? 1'b0 : pend16;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    repeat (gap) tick();
    rx_data = d;
    rx_tick = 1'b1;
    tick();
    rx_tick = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] opb, input logic [15:0] a, input logic [15:0] b, input int maxgap);
    int nb;
    nb = sel16 ? 2 : 1;
    send_byte(opb, $urandom_range(0, maxgap));
    for (int k = 0; k < nb; k++) send_byte(8'(a >> (8 * k)), $urandom_range(0, maxgap));
    for (int k = 0; k < nb; k++) send_byte(8'(b >> (8 * k)), $urandom_range(0, maxgap));
  endtask

  // Entered in the cycle right after the last B byte was taken.
  task automatic serve_tx(input logic [15:0] exp_res, input bit inject);
    int nb, n;
    logic [7:0] eb;
    nb = sel16 ? 2 : 1;
    chk("exec_no_tx_start", {cur_busy, cur_ts}, 2'b10);
    tick();
    chk("latency_tx_start", cur_ts, 1'b1);
    for (int k = 0; k < nb; k++) begin
      eb = 8'(exp_res >> (8 * k));
      if (k > 0) begin
        n = 0;
        while (!cur_ts && n < 20) begin tick(); n++; end
        chk("tx_start_next_byte", cur_ts, 1'b1);
      end
      chk("data_out_byte", cur_d, eb);
      if (inject && k == 0) begin
        tick();
        send_byte(8'h77, 0);
        chk("rx_in_tx_wait_hold", {cur_ts, cur_d}, {1'b0, eb});
      end
      repeat ($urandom_range(1, 4)) begin
        tick();
        chk("tx_wait_hold", {cur_busy, cur_ts, cur_d}, {2'b10, eb});
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    chk("busy_after_last_tx_done", cur_busy, 1'b0);
  endtask

  task automatic check_regs(input logic [7:0] opb, input logic [15:0] a, input logic [15:0] b);
    chk("opcode_reg", cur_op, opb[5:0]);
    chk("a_reg", cur_a, a);
    chk("b_reg", cur_b, b);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {cur_ts, cur_d, cur_a, cur_b, cur_op, cur_busy, cur_fe}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0]  opb;
    logic [15:0] a, b, res;
    logic [7:0]  ops [5];
    int          n, base;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26};

    reset = 1'b0; rx_tick = 1'b0; tx_done = 1'b0; rx_data = 8'h00; sel16 = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_state_8");
    sel16 = 1'b1;
    check_all_zero("reset_state_16");
    reset = 1'b1;
    tick();

    // 8-bit ADD
    sel16 = 1'b0;
    send_frame(8'h20, 16'h0005, 16'h0003, 0);
    serve_tx(16'h0008, 1'b0);
    check_regs(8'h20, 16'h0005, 16'h0003);

    // 16-bit ADD, bytes LSB first
    sel16 = 1'b1;
    send_frame(8'h20, 16'h1234, 16'h0001, 0);
    serve_tx(16'h1235, 1'b0);
    check_regs(8'h20, 16'h1234, 16'h0001);

    // tx_done outside TX_WAIT is ignored
    base = ts_cnt16;
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    repeat (3) tick();
    chk("tx_done_idle_ignored", {cur_busy, 32'(ts_cnt16 - base)}, '0);

    // stray rx byte during TX_WAIT
    send_frame(8'h22, 16'h5000, 16'h0123, 3);
    serve_tx(16'h4EDD, 1'b1);
    check_regs(8'h22, 16'h5000, 16'h0123);
    send_frame(8'hE6, 16'hA5A5, 16'h0FF0, 2);
    serve_tx(16'hAA55, 1'b0);
    check_regs(8'h26, 16'hA5A5, 16'h0FF0);

    // inter-byte timeout on 8-bit frame
    sel16 = 1'b0;
    base = fe_cnt8;
    send_byte(8'h20, 0);
    send_byte(8'h05, 0);
    n = 0;
    while (!cur_fe && n < T + 5) begin tick(); n++; end
    chk("timeout_frame_err", cur_fe, 1'b1);
    chk("timeout_delay_window", (n >= T - 1) && (n <= T + 1), 1'b1);
    tick();
    chk("timeout_pulse_end_idle", {cur_fe, cur_busy}, 2'b00);
    chk("timeout_pulse_count", fe_cnt8 - base, 1);
    chk("timeout_partial_a", cur_a, 16'h0005);
    send_frame(8'h24, 16'h003C, 16'h0017, 3);
    serve_tx(16'h0014, 1'b0);
    check_regs(8'h24, 16'h003C, 16'h0017);

    // byte arriving in the timeout cycle is accepted
    base = fe_cnt8;
    send_byte(8'h25, 0);
    send_byte(8'h41, T);
    send_byte(8'h12, T);
    serve_tx(16'h0053, 1'b0);
    chk("same_cycle_byte_wins", fe_cnt8 - base, 0);

    // randomized frames against the reference model
    for (int i = 0; i < 10; i++) begin
      sel16 = 1'($urandom_range(0, 1));
      opb = ops[$urandom_range(0, 4)] | 8'($urandom_range(0, 3) << 6);
      a   = 16'($urandom);
      b   = 16'($urandom);
      if (!sel16) begin a[15:8] = 8'h00; b[15:8] = 8'h00; end
      res = ref_alu({2'b00, opb[5:0]}, a, b);
      if (!sel16) res[15:8] = 8'h00;
      send_frame(opb, a, b, 4);
      serve_tx(res, 1'($urandom_range(0, 1)));
      check_regs(opb, a, b);
    end

    // reset during TX_WAIT of a 16-bit frame
    sel16 = 1'b1;
    send_frame(8'h20, 16'hABCD, 16'h1111, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_all_zero("reset_in_tx_wait");
    reset = 1'b1;
    base = ts_cnt16;
    repeat (4) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    repeat (5) tick();
    chk("no_tx_start_after_reset", {cur_busy, 32'(ts_cnt16 - base)}, '0);
    send_frame(8'h20, 16'h00FF, 16'h0001, 1);
    serve_tx(16'h0100, 1'b0);
    check_regs(8'h20, 16'h00FF, 16'h0001);

    tick();
    chk("no_double_tx_start", dbl_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
